// File: rtl/nes_pad_mailbox_writer.sv
// NES controller poller that commits pad state into one word of an Avalon mailbox RAM.
// Optional build macro NES_PAD_WRITE_ON_CHANGE_EN: skip the RAM write when button state is unchanged.
module nes_pad_mailbox_writer #(
  parameter int         HALF_BIT = 12,
  parameter int         POLL_DIV = 60000,
  parameter int         NUM_PADS = 2,
  parameter logic [1:0] WR_ADDR  = 2'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        freeze,
  input  logic [1:0]  pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [1:0]  mem_address,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  output logic        mem_clken,
  output logic [7:0]  buttons0,
  output logic [7:0]  buttons1,
  output logic        poll_done
);

  localparam int PW = $clog2(2 * HALF_BIT);
  localparam int CW = $clog2(POLL_DIV);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * HALF_BIT - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(HALF_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [PW-1:0]   phase_r;
  logic [PW-1:0]   phase_nxt_s;
  logic [2:0]      bit_r;
  logic [2:0]      bit_nxt_s;
  logic [7:0]      sh0_r;
  logic [7:0]      sh1_r;
  logic [7:0]      sh0_nxt_s;
  logic [7:0]      sh1_nxt_s;
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [CW-1:0]   poll_cnt_r;
  logic [15:0]     seq_r;
  logic [7:0]      buttons0_r;
  logic [7:0]      buttons1_r;
  logic [31:0]     writedata_r;
  logic            pad_latch_r;
  logic            pad_clk_r;
  logic            strobe_r;
  logic            clken_r;
  logic            tick_s;
  logic            smp0_s;
  logic            smp1_s;
  logic            latch_nxt_s;
  logic            pclk_nxt_s;
  logic            do_write_s;
  logic            need_hold_s;
  logic            need_nxt_s;

  assign tick_s = (poll_cnt_r == CNT_LAST);
  assign smp0_s = ~sync2_r[0];
  assign smp1_s = (NUM_PADS == 2) ? ~sync2_r[1] : 1'b0;

`ifdef NES_PAD_WRITE_ON_CHANGE_EN
  logic first_done_r;

  // Remembers whether a write has been issued since reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_done_r <= 1'b0;
    end else if (do_write_s) begin
      first_done_r <= 1'b1;
    end else begin
      first_done_r <= first_done_r;
    end
  end

  // The first poll always writes; later polls only on a change
  assign need_hold_s = !first_done_r || ({sh1_r, sh0_r} != {buttons1_r, buttons0_r});
  assign need_nxt_s  = !first_done_r || ({sh1_nxt_s, sh0_nxt_s} != {buttons1_r, buttons0_r});
`else
  assign need_hold_s = 1'b1;
  assign need_nxt_s  = 1'b1;
`endif

  // Two-flop synchronizer on the pad serial lines
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
    end else begin
      sync1_r <= pad_data;
      sync2_r <= sync1_r;
    end
  end

  // Free-running poll interval counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt_r <= '0;
    end else if (tick_s) begin
      poll_cnt_r <= '0;
    end else begin
      poll_cnt_r <= poll_cnt_r + CW'(1);
    end
  end

  // FSM state and bit-timing registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      phase_r <= '0;
      bit_r   <= 3'd0;
      sh0_r   <= 8'h00;
      sh1_r   <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      phase_r <= phase_nxt_s;
      bit_r   <= bit_nxt_s;
      sh0_r   <= sh0_nxt_s;
      sh1_r   <= sh1_nxt_s;
    end
  end

  // Next-state logic: latch pulse, seven shift bits, then the write slot
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    bit_nxt_s   = bit_r;
    sh0_nxt_s   = sh0_r;
    sh1_nxt_s   = sh1_r;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && !freeze) begin
          state_nxt_s = ST_LATCH;
          phase_nxt_s = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (phase_r == PH_LAST) begin
          sh0_nxt_s   = {7'd0, smp0_s};
          sh1_nxt_s   = {7'd0, smp1_s};
          state_nxt_s = ST_SHIFT;
          phase_nxt_s = '0;
          bit_nxt_s   = 3'd1;
        end else begin
          phase_nxt_s = phase_r + PW'(1);
        end
      end
      ST_SHIFT: begin
        if (phase_r == PH_LAST) begin
          sh0_nxt_s[bit_r] = smp0_s;
          sh1_nxt_s[bit_r] = smp1_s;
          phase_nxt_s      = '0;
          if (bit_r == 3'd7) begin
            state_nxt_s = ST_WRITE;
          end else begin
            bit_nxt_s = bit_r + 3'd1;
          end
        end else begin
          phase_nxt_s = phase_r + PW'(1);
        end
      end
      ST_WRITE: begin
        // The write strobe is registered, so leave once it is showing
        if (strobe_r) begin
          state_nxt_s = ST_IDLE;
        end else if (!freeze && !need_hold_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    latch_nxt_s = 1'b0;
    pclk_nxt_s  = 1'b1;
    do_write_s  = 1'b0;
    if (state_nxt_s == ST_LATCH) begin
      latch_nxt_s = 1'b1;
    end else begin
      latch_nxt_s = 1'b0;
    end
    if ((state_nxt_s == ST_SHIFT) && (phase_nxt_s < PH_HALF)) begin
      pclk_nxt_s = 1'b0;
    end else begin
      pclk_nxt_s = 1'b1;
    end
    if ((state_nxt_s == ST_WRITE) && !freeze && !strobe_r && need_nxt_s) begin
      do_write_s = 1'b1;
    end else begin
      do_write_s = 1'b0;
    end
  end

  // Registered pad lines and RAM strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_latch_r <= 1'b0;
      pad_clk_r   <= 1'b1;
      strobe_r    <= 1'b0;
      clken_r     <= 1'b0;
    end else begin
      pad_latch_r <= latch_nxt_s;
      pad_clk_r   <= pclk_nxt_s;
      strobe_r    <= do_write_s;
      clken_r     <= 1'b1;
    end
  end

  // Committed data: write word, visible button state and sequence number
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      writedata_r <= 32'h0000_0000;
      buttons0_r  <= 8'h00;
      buttons1_r  <= 8'h00;
      seq_r       <= 16'h0000;
    end else if (do_write_s) begin
      writedata_r <= {seq_r, sh1_nxt_s, sh0_nxt_s};
      buttons0_r  <= sh0_nxt_s;
      buttons1_r  <= sh1_nxt_s;
      seq_r       <= seq_r + 16'd1;
    end else begin
      writedata_r <= writedata_r;
      buttons0_r  <= buttons0_r;
      buttons1_r  <= buttons1_r;
      seq_r       <= seq_r;
    end
  end

  assign pad_latch      = pad_latch_r;
  assign pad_clk        = pad_clk_r;
  assign mem_address    = WR_ADDR;
  assign mem_chipselect = strobe_r;
  assign mem_write      = strobe_r;
  assign mem_byteenable = strobe_r ? 4'hF : 4'h0;
  assign mem_writedata  = writedata_r;
  assign mem_clken      = clken_r;
  assign buttons0       = buttons0_r;
  assign buttons1       = buttons1_r;
  assign poll_done      = strobe_r;

endmodule

// File: tb/tb_nes_pad_mailbox_writer.sv
// Randomized bench for nes_pad_mailbox_writer with a behavioural pad model and poll scoreboard.
module tb_nes_pad_mailbox_writer;

  localparam int HB = 4;
  localparam int PD = 80;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        freeze = 1'b0;
  logic [1:0]  pad_data;
  logic        pad_latch;
  logic        pad_clk;
  logic [1:0]  mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [7:0]  buttons0;
  logic [7:0]  buttons1;
  logic        poll_done;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  logic [7:0]  btn0 = 8'h00;
  logic [7:0]  btn1 = 8'h00;
  logic [7:0]  sr0 = 8'h00;
  logic [7:0]  sr1 = 8'h00;
  logic        pclk_q = 1'b1;
  logic [15:0] seq_m = 16'h0000;

  nes_pad_mailbox_writer #(
    .HALF_BIT(HB),
    .POLL_DIV(PD),
    .NUM_PADS(2),
    .WR_ADDR(2'd1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .freeze(freeze),
    .pad_data(pad_data),
    .pad_latch(pad_latch),
    .pad_clk(pad_clk),
    .mem_address(mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata),
    .mem_clken(mem_clken),
    .buttons0(buttons0),
    .buttons1(buttons1),
    .poll_done(poll_done)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load while latched, shift towards bit 0 on pad_clk rise
  assign pad_data = ~{sr1[0], sr0[0]};
  always @(posedge clk) begin
    pclk_q <= pad_clk;
    if (pad_latch) begin
      sr0 <= btn0;
      sr1 <= btn1;
    end else if (pad_clk && !pclk_q) begin
      sr0 <= {1'b0, sr0[7:1]};
      sr1 <= {1'b0, sr1[7:1]};
    end
  end

  // Cycles since reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic rand_btns();
    logic [15:0] v;
    v = 16'($urandom);
    if (v == {btn1, btn0}) v[0] = ~v[0];
    {btn1, btn0} = v;
  endtask

  task automatic wait_latch(input string tag, output int t_l);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = pad_latch;
    end
    check({tag, "/latch_seen"}, 32'(seen), 32'd1);
    t_l = cyc;
  endtask

  task automatic run_poll(input string tag, input bit frz, input int exp_latch);
    int t_l, t_w, t_r;
    bit seen, early;
    logic [31:0] exp_wd;
    wait_latch(tag, t_l);
    if (exp_latch > 0) check({tag, "/latch_cyc"}, 32'(t_l), 32'(exp_latch));
    else check({tag, "/latch_phase"}, 32'(t_l % PD), 32'd0);
    exp_wd = {seq_m, btn1, btn0};
    t_r = t_l;
    early = 1'b0;
    if (frz) begin
      repeat (20) @(negedge clk);
      freeze = 1'b1;
      while (cyc < t_l + 16 * HB + 20) begin
        @(negedge clk);
        if (mem_write || mem_chipselect || poll_done) early = 1'b1;
      end
      freeze = 1'b0;
      t_r = cyc;
      check({tag, "/no_strobe_frozen"}, 32'(early), 32'd0);
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = mem_write;
    end
    check({tag, "/write_seen"}, 32'(seen), 32'd1);
    t_w = cyc;
    if (frz) check({tag, "/write_after_release"}, 32'(t_w - t_r), 32'd1);
    else check({tag, "/latency"}, 32'(t_w - t_l), 32'(16 * HB));
    check({tag, "/writedata"}, mem_writedata, exp_wd);
    check({tag, "/addr_be_cs_pd"}, {24'd0, mem_address, mem_byteenable, mem_chipselect, poll_done},
          {24'd0, 2'd1, 4'hF, 1'b1, 1'b1});
    check({tag, "/buttons"}, {16'd0, buttons1, buttons0}, {16'd0, btn1, btn0});
    @(negedge clk);
    check({tag, "/one_cycle"}, {25'd0, mem_write, mem_chipselect, poll_done, mem_byteenable},
          32'd0);
    seq_m = seq_m + 16'd1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    seq_m = 16'h0000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t_l;
    reset_n = 1'b0;
    freeze  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/pad_lines", {30'd0, pad_latch, pad_clk}, {30'd0, 1'b0, 1'b1});
    check("rst/strobes", {25'd0, mem_write, mem_chipselect, poll_done, mem_byteenable}, 32'd0);
    check("rst/writedata", mem_writedata, 32'd0);
    check("rst/clken", 32'(mem_clken), 32'd0);
    check("rst/buttons", {16'd0, buttons1, buttons0}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("clken_after_release", 32'(mem_clken), 32'd1);

    btn0 = 8'h00; btn1 = 8'h00;
    run_poll("idle_pads", 1'b0, PD);
    check("idle_pads/word", mem_writedata, 32'h0000_0000);

    btn0 = 8'h09; btn1 = 8'h80;
    run_poll("a_start_right", 1'b0, -1);
    check("a_start_right/word", mem_writedata, 32'h0001_8009);

    for (int k = 0; k < 4; k++) begin
      rand_btns();
      run_poll("random", 1'b0, -1);
    end

    rand_btns();
    run_poll("freeze", 1'b1, -1);
    rand_btns();
    run_poll("post_freeze", 1'b0, -1);

    // Reset in the middle of the shift phase
    rand_btns();
    wait_latch("mid_reset", t_l);
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset/pad_lines", {30'd0, pad_latch, pad_clk}, {30'd0, 1'b0, 1'b1});
    check("mid_reset/strobes", {25'd0, mem_write, mem_chipselect, poll_done, mem_byteenable}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seq_m = 16'h0000;
    rand_btns();
    run_poll("after_reset", 1'b0, PD);

    force dut.seq_r = 16'hFFFF;
    @(negedge clk);
    release dut.seq_r;
    seq_m = 16'hFFFF;
    rand_btns();
    run_poll("seq_ffff", 1'b0, -1);
    check("seq_ffff/hi", {16'd0, mem_writedata[31:16]}, 32'h0000_FFFF);
    rand_btns();
    run_poll("seq_wrap", 1'b0, -1);
    check("seq_wrap/hi", {16'd0, mem_writedata[31:16]}, 32'h0000_0000);

`ifdef NES_PAD_WRITE_ON_CHANGE_EN
    do_reset();
    btn0 = 8'h11; btn1 = 8'h22;
    run_poll("onchange_first", 1'b0, PD);
    for (int k = 0; k < 2; k++) begin
      bit wrote;
      wait_latch("onchange_same", t_l);
      wrote = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (mem_write || poll_done) wrote = 1'b1;
      end
      check("onchange_same/no_write", 32'(wrote), 32'd0);
    end
    btn0 = 8'h12;
    run_poll("onchange_changed", 1'b0, -1);
    check("onchange_changed/seq", {16'd0, mem_writedata[31:16]}, 32'h0000_0001);
`else
    do_reset();
    btn0 = 8'h11; btn1 = 8'h22;
    run_poll("repeat_first", 1'b0, PD);
    run_poll("repeat_same", 1'b0, -1);
    check("repeat_same/seq", {16'd0, mem_writedata[31:16]}, 32'h0000_0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
